core_dispatch_queue: RTL and testbench
======================================

CORE_DISPATCH_QUEUE -- requirements
Module: core_dispatch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Ports SHALL be, in order:
  - clk  in  1  core clock
  - rst_n  in  1  async active-low reset
  - in_a  in  insn_decode  older decoded insn from decode
  - in_b  in  insn_decode  younger decoded insn from decode
  - in_valid_a  in  1  in_a present
  - in_valid_b  in  1  in_b present; legal only with in_valid_a
  - in_ready  out  1  queue accepts a pair this cycle
  - flush  in  1  discard all entries (branch redirect)
  - dispatch_a  in  1  hazard check issued cur_a
  - dispatch_b  in  1  hazard check issued cur_b
  - cur_a  out  insn_decode  oldest entry
  - cur_b  out  insn_decode  second-oldest entry
  - count  out  $clog2(DEPTH)+1  occupied entries
REQ-003 Parameter DEPTH SHALL default to 8, SHALL be a power of two, and SHALL be at least 4.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH insn_decode entries with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-005 cur_a SHALL equal the entry at head when count>=1, and otherwise SHALL equal INSN_BUBBLE (ctrl.execute=0, data.writeback=0).
REQ-006 cur_b SHALL equal the entry at head+1 (mod DEPTH) when count>=2, and otherwise SHALL equal INSN_BUBBLE.
REQ-007 cur_a and cur_b SHALL be read combinationally from registered storage, so an entry pushed in cycle N is visible on cur_a or cur_b in cycle N+1.
REQ-008 in_ready SHALL be 1 iff registered count <= DEPTH-2, and SHALL NOT depend combinationally on dispatch_a, dispatch_b, or flush.
REQ-009 Push: when in_ready=1 and in_valid_a=1, in_a SHALL be written at tail; when in_valid_b=1 as well, in_b SHALL be written at tail+1; tail SHALL advance by 1 or 2 accordingly.
REQ-010 Input with in_valid_a=1 while in_ready=0 SHALL be ignored; decode holds it.
REQ-011 Input with in_valid_b=1 and in_valid_a=0 SHALL be treated as no push.
REQ-012 The pop amount SHALL be computed as follows:
  - pop=2 when dispatch_a=1, dispatch_b=1, and count>=2;
  - else pop=1 when dispatch_a=1 and count>=1;
  - else pop=0.
REQ-013 Pop SHALL ignore dispatch_b while dispatch_a=0.
REQ-014 A dispatch asserted against an INSN_BUBBLE slot SHALL pop nothing.
REQ-015 head SHALL advance by the pop amount.
REQ-016 Push and pop in the same cycle SHALL both take effect, with count_next = count + push - pop.
REQ-017 flush=1 SHALL override both push and pop: next cycle head=tail=0, count=0, and cur_a/cur_b=INSN_BUBBLE.
REQ-018 count SHALL never exceed DEPTH and SHALL never underflow.
REQ-019 Program order SHALL be preserved: in_a is older than in_b, and both are younger than every resident entry.

Reset
REQ-020 While rst_n=0, the block SHALL hold head=0, tail=0, count=0, in_ready=1, and cur_a=cur_b=INSN_BUBBLE, asynchronously.
REQ-021 After rst_n deasserts, the first push SHALL be accepted on the first rising clk edge.
REQ-022 Storage contents SHALL NOT require reset, and outputs SHALL be masked by count.
REQ-023 Reset asserted mid-operation SHALL discard all entries, identically to flush.

Structure
REQ-024 INSN_BUBBLE and the default DEPTH constant SHALL live in the shared uarch package alongside insn_decode.
REQ-025 The block SHALL be a single module with no sub-modules; pointer and count arithmetic SHALL be local.

Verification
REQ-026 Reset: assert rst_n=0 mid-stream -> count=0, in_ready=1, and cur_a.ctrl.execute=0 immediately, without waiting for clk.
REQ-027 Fill: push pairs for 4 cycles with dispatch low -> count reads 2, 4, 6, 8; in_ready=0 at count=8; a 5th pair is dropped and count stays 8.
REQ-028 Partial issue: 3 entries I0..I2 resident, dispatch_a=1, dispatch_b=0 -> next cur_a=I1, cur_b=I2, count=2.
REQ-029 Dual issue with push: 3 entries resident, dispatch_a=dispatch_b=1, and a pair I3,I4 pushed -> next count=3, cur_a=I2, cur_b=I3.
REQ-030 Wrap-around: push 6, pop 6, then push 4 -> entries are returned in order across the index-7-to-0 boundary, and count=4.
REQ-031 Flush: flush=1 together with a valid push and dispatch_a=1 at count=5 -> next count=0, cur_a=cur_b=INSN_BUBBLE, and the pushed pair is discarded.

Source files
------------

// File: rtl/core_dispatch_queue_pkg.sv
// Shared micro-architecture definitions for the dispatch queue.
//   insn_decode  : decoded instruction record (ctrl + data fields)
//   INSN_BUBBLE  : no-op slot (execute=0, writeback=0)
//   CDQ_DEPTH    : default queue depth
package core_dispatch_queue_pkg;

   localparam int unsigned CDQ_DEPTH = 8;

   typedef struct packed {
      logic       execute;
      logic [3:0] opcode;
   } insn_ctrl_t;

   typedef struct packed {
      logic        writeback;
      logic [4:0]  rd;
      logic [15:0] imm;
   } insn_data_t;

   typedef struct packed {
      insn_ctrl_t ctrl;
      insn_data_t data;
   } insn_decode;

   localparam insn_decode INSN_BUBBLE = '0;

endpackage

// File: rtl/core_dispatch_queue.sv
// Dual-issue in-order dispatch queue between decode and hazard check.
// Ports:
//   clk, rst_n              : core clock, async active-low reset
//   in_a, in_b              : older / younger decoded insn from decode
//   in_valid_a, in_valid_b  : insn present (b only meaningful with a)
//   in_ready                : room for a full pair this cycle
//   flush                   : discard all entries (branch redirect)
//   dispatch_a, dispatch_b  : hazard check issued cur_a / cur_b
//   cur_a, cur_b            : oldest / second-oldest entry, bubble if absent
//   count                   : occupied entries
module core_dispatch_queue
   import core_dispatch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = CDQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  insn_decode               in_a,
   input  insn_decode               in_b,
   input  logic                     in_valid_a,
   input  logic                     in_valid_b,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     dispatch_a,
   input  logic                     dispatch_b,
   output insn_decode               cur_a,
   output insn_decode               cur_b,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("DEPTH must be a power of two and at least 4");
   end

   insn_decode      mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   head_p1;
   logic [PW-1:0]   tail_p1;
   logic [1:0]      push_n;
   logic [1:0]      pop_n;

   assign head_p1  = head + PW'(1);
   assign tail_p1  = tail + PW'(1);

   // Ready only from registered count so decode never sees a path from dispatch.
   assign in_ready = (count <= CW'(DEPTH - 2));

   // Storage is unreset; count masks stale contents to bubbles.
   assign cur_a = (count >= CW'(1)) ? mem[head]    : INSN_BUBBLE;
   assign cur_b = (count >= CW'(2)) ? mem[head_p1] : INSN_BUBBLE;

   always_comb begin
      push_n = 2'd0;
      if (in_ready && in_valid_a && !flush)
         push_n = in_valid_b ? 2'd2 : 2'd1;

      // Pop is bounded by occupancy so a dispatch against a bubble is a no-op.
      pop_n = 2'd0;
      if (dispatch_a && dispatch_b && count >= CW'(2))
         pop_n = 2'd2;
      else if (dispatch_a && count >= CW'(1))
         pop_n = 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(pop_n);
         tail  <= tail + PW'(push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   always_ff @(posedge clk) begin
      if (push_n != 2'd0)
         mem[tail] <= in_a;
      if (push_n == 2'd2)
         mem[tail_p1] <= in_b;
   end

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Self-checking bench for core_dispatch_queue: vector table plus
// hand-written multi-cycle sequences, checked against a queue model.
module tb_core_dispatch_queue;
   import core_dispatch_queue_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic        clk;
   logic        rst_n;
   insn_decode  in_a, in_b, cur_a, cur_b;
   logic        in_valid_a, in_valid_b, in_ready;
   logic        flush, dispatch_a, dispatch_b;
   logic [3:0]  count;

   core_dispatch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_valid_a (in_valid_a),
      .in_valid_b (in_valid_b),
      .in_ready   (in_ready),
      .flush      (flush),
      .dispatch_a (dispatch_a),
      .dispatch_b (dispatch_b),
      .cur_a      (cur_a),
      .cur_b      (cur_b),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int serial = 1;
   insn_decode mq[$];

   typedef struct {
      logic va, vb, da, db, fl;
      int   exp_count;
      logic exp_ready;
   } vec_t;

   function automatic insn_decode mk(input int n);
      insn_decode r;
      r.ctrl.execute   = 1'b1;
      r.ctrl.opcode    = n[3:0];
      r.data.writeback = 1'b1;
      r.data.rd        = n[8:4];
      r.data.imm       = n[15:0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      insn_decode ea, eb;
      ea = (mq.size() >= 1) ? mq[0] : INSN_BUBBLE;
      eb = (mq.size() >= 2) ? mq[1] : INSN_BUBBLE;
      chk({tag, "_count"}, 64'(count), 64'(mq.size()));
      chk({tag, "_ready"}, 64'(in_ready), 64'(mq.size() <= int'(DEPTH) - 2));
      chk({tag, "_cur_a"}, 64'(cur_a), 64'(ea));
      chk({tag, "_cur_b"}, 64'(cur_b), 64'(eb));
   endtask

   // Drive one cycle of stimulus, advance the model, return at posedge+1.
   task automatic apply(input logic va, vb, da, db, fl);
      int  sz, pop;
      bit  rdy;
      in_a = mk(serial);
      in_b = mk(serial + 1);
      serial += 2;
      in_valid_a = va; in_valid_b = vb;
      dispatch_a = da; dispatch_b = db; flush = fl;
      sz  = mq.size();
      rdy = (sz <= int'(DEPTH) - 2);
      if (fl) mq.delete();
      else begin
         pop = (da && db && sz >= 2) ? 2 : ((da && sz >= 1) ? 1 : 0);
         repeat (pop) void'(mq.pop_front());
         if (rdy && va) begin
            mq.push_back(in_a);
            if (vb) mq.push_back(in_b);
         end
      end
      @(posedge clk);
      #1;
      in_valid_a = 0; in_valid_b = 0; dispatch_a = 0; dispatch_b = 0; flush = 0;
   endtask

   vec_t vecs[13];
   int   s0, s1;

   initial begin
      vecs[0]  = '{1,1,0,0,0, 2, 1};
      vecs[1]  = '{1,1,0,0,0, 4, 1};
      vecs[2]  = '{1,1,0,0,0, 6, 1};
      vecs[3]  = '{1,1,0,0,0, 8, 0};
      vecs[4]  = '{1,1,0,0,0, 8, 0};  // dropped while full
      vecs[5]  = '{0,0,1,1,0, 6, 1};
      vecs[6]  = '{0,1,1,0,0, 5, 1};  // b without a: no push
      vecs[7]  = '{1,0,0,1,0, 6, 1};  // dispatch_b alone: no pop
      vecs[8]  = '{1,1,1,1,0, 6, 1};
      vecs[9]  = '{0,0,1,1,1, 0, 1};
      vecs[10] = '{0,0,1,1,0, 0, 1};  // dispatch on bubbles
      vecs[11] = '{1,0,1,1,0, 1, 1};
      vecs[12] = '{0,0,1,1,0, 0, 1};

      rst_n = 0; in_a = '0; in_b = '0;
      in_valid_a = 0; in_valid_b = 0; dispatch_a = 0; dispatch_b = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 13; i++) begin
         apply(vecs[i].va, vecs[i].vb, vecs[i].da, vecs[i].db, vecs[i].fl);
         chk($sformatf("vec%0d_count_tbl", i), 64'(count), 64'(vecs[i].exp_count));
         chk($sformatf("vec%0d_ready_tbl", i), 64'(in_ready), 64'(vecs[i].exp_ready));
         check_model($sformatf("vec%0d", i));
      end

      // Partial issue
      apply(0,0,0,0,1);
      s0 = serial; apply(1,1,0,0,0);
      s1 = serial; apply(1,0,0,0,0);
      apply(0,0,1,0,0);
      chk("partial_count", 64'(count), 64'd2);
      chk("partial_cur_a", 64'(cur_a), 64'(mk(s0 + 1)));
      chk("partial_cur_b", 64'(cur_b), 64'(mk(s1)));
      check_model("partial");

      // Dual issue with simultaneous push
      apply(0,0,0,0,1);
      s0 = serial; apply(1,1,0,0,0);
      s1 = serial; apply(1,0,0,0,0);
      s0 = serial; apply(1,1,1,1,0);
      chk("dual_count", 64'(count), 64'd3);
      chk("dual_cur_a", 64'(cur_a), 64'(mk(s1)));
      chk("dual_cur_b", 64'(cur_b), 64'(mk(s0)));
      check_model("dual");

      // Wrap-around across index 7 -> 0
      apply(0,0,0,0,1);
      repeat (3) apply(1,1,0,0,0);
      repeat (3) apply(0,0,1,1,0);
      s0 = serial;
      repeat (2) apply(1,1,0,0,0);
      chk("wrap_count", 64'(count), 64'd4);
      chk("wrap0_a", 64'(cur_a), 64'(mk(s0)));
      chk("wrap0_b", 64'(cur_b), 64'(mk(s0 + 1)));
      apply(0,0,1,0,0);
      chk("wrap1_a", 64'(cur_a), 64'(mk(s0 + 1)));
      chk("wrap1_b", 64'(cur_b), 64'(mk(s0 + 2)));
      apply(0,0,1,0,0);
      chk("wrap2_a", 64'(cur_a), 64'(mk(s0 + 2)));
      chk("wrap2_b", 64'(cur_b), 64'(mk(s0 + 3)));
      apply(0,0,1,0,0);
      chk("wrap3_a", 64'(cur_a), 64'(mk(s0 + 3)));
      chk("wrap3_b", 64'(cur_b), 64'(INSN_BUBBLE));
      check_model("wrap");

      // Flush overrides push and pop
      apply(0,0,0,0,1);
      apply(1,1,0,0,0); apply(1,1,0,0,0); apply(1,0,0,0,0);
      chk("preflush_count", 64'(count), 64'd5);
      apply(1,1,1,0,1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_cur_a", 64'(cur_a), 64'(INSN_BUBBLE));
      chk("flush_cur_b", 64'(cur_b), 64'(INSN_BUBBLE));
      apply(0,0,0,0,0);
      chk("flush_discard", 64'(count), 64'd0);

      // Asynchronous reset mid-stream, then immediate push
      apply(1,1,0,0,0); apply(1,1,0,0,0);
      #2 rst_n = 0;
      #1;
      mq.delete();
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_ready", 64'(in_ready), 64'd1);
      chk("async_rst_exec", 64'(cur_a.ctrl.execute), 64'd0);
      @(negedge clk);
      rst_n = 1;
      s0 = serial; apply(1,0,0,0,0);
      chk("post_rst_count", 64'(count), 64'd1);
      chk("post_rst_cur_a", 64'(cur_a), 64'(mk(s0)));
      check_model("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
